// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: drives a 1-cycle synchronous imem and holds {pc, insn} pairs in a DEPTH-entry prefetch queue.
// Build with IF_FETCH_PERF_EN defined to add saturating perf_fetched / perf_flushes counters.
module if_fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_INC   = 4
) (
   input  logic                       Clk,
   input  logic                       reset,
   input  logic                       isBranchTaken,
   input  logic [ADDR_W-1:0]          branchPC,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [DATA_W-1:0]          imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W-1:0]          pc_current,
   output logic [DATA_W-1:0]          Instruction,
   output logic [$clog2(DEPTH):0]     fifo_count
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]                perf_fetched,
   output logic [15:0]                perf_flushes
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
   logic [ADDR_W-1:0] pc_mem_d  [DEPTH];
   logic [DATA_W-1:0] ins_mem_q [DEPTH];
   logic [DATA_W-1:0] ins_mem_d [DEPTH];

   logic [CNT_W:0] occ;
   logic           issue;
   logic           push;
   logic           pop;

   // Counting the in-flight fetch as occupied guarantees the returning word a slot.
   assign occ   = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
   assign issue = !reset && !isBranchTaken && (occ < (CNT_W+1)'(DEPTH));
   assign push  = inflight_q && !isBranchTaken;
   assign pop   = out_valid && out_ready && !isBranchTaken;

   assign imem_req    = issue;
   assign imem_addr   = fetch_pc_q;
   assign out_valid   = (count_q != '0);
   assign fifo_count  = count_q;
   assign pc_current  = pc_mem_q[rd_ptr_q];
   assign Instruction = ins_mem_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      pc_mem_d      = pc_mem_q;
      ins_mem_d     = ins_mem_q;
      if (issue) begin
         fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_INC);
         inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
         pc_mem_d[wr_ptr_q]  = inflight_pc_q;
         ins_mem_d[wr_ptr_q] = imem_rdata;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Redirect wins over push/pop; no fetch is issued this cycle so nothing stays in flight.
      if (isBranchTaken) begin
         fetch_pc_d = branchPC;
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         pc_mem_q      <= pc_mem_d;
         ins_mem_q     <= ins_mem_d;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [15:0] perf_flushes_q, perf_flushes_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_flushes_d = perf_flushes_q;
      if (pop && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
      if (isBranchTaken && (perf_flushes_q != '1)) perf_flushes_d = perf_flushes_q + 16'd1;
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushes_q <= perf_flushes_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushes = perf_flushes_q;
`endif

endmodule
